// File: rtl/keypad_emulator.sv
// Passive 4x4 keypad model: closes one commanded key for a timed hold, with optional
// LFSR-driven contact chatter on make and break, and reflects scanned columns onto rows.
module keypad_emulator #(
    parameter int unsigned BOUNCE_CYCLES = 48000,
    parameter int unsigned CHATTER_DIV   = 480,
    parameter int unsigned GAP_CYCLES    = 48000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        press_req,
    input  logic [3:0]  press_key,
    input  logic [23:0] press_hold,
    input  logic        press_bounce,
    output logic        busy,
    output logic        done,
    input  logic [3:0]  keypad_vert,
    output logic [3:0]  keypad_hori,
    output logic        contact
);
    localparam int unsigned DIV_W = $clog2(CHATTER_DIV) + 1;
    localparam logic [23:0] BOUNCE_M1 = 24'(BOUNCE_CYCLES - 1);
    localparam logic [23:0] GAP_M1    = 24'(GAP_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_M1 = DIV_W'(CHATTER_DIV - 1);

    typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_t;

    state_t           state, state_nx;
    logic [23:0]      cnt, cnt_nx;
    logic             done_q, done_nx;
    logic [15:0]      lfsr;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       key_q;
    logic [23:0]      hold_q;
    logic             bounce_q;
    logic [23:0]      req_hold_m1, hold_m1;
    logic             in_bounce;

    // A zero hold request still gives one cycle of solid contact.
    assign req_hold_m1 = (press_hold == 24'd0) ? 24'd0 : press_hold - 24'd1;
    assign hold_m1     = (hold_q == 24'd0) ? 24'd0 : hold_q - 24'd1;
    assign in_bounce   = (state == BOUNCE_IN) || (state == BOUNCE_OUT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 24'd0;
            done_q   <= 1'b0;
            lfsr     <= LFSR_SEED;
            div_cnt  <= '0;
            key_q    <= 4'd0;
            hold_q   <= 24'd0;
            bounce_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            done_q <= done_nx;
            if (state == IDLE && press_req) begin
                key_q    <= press_key;
                hold_q   <= press_hold;
                bounce_q <= press_bounce;
            end
            // The divider restarts at each chatter phase; the LFSR keeps its value across presses.
            if (in_bounce) begin
                if (div_cnt == DIV_M1) begin
                    div_cnt <= '0;
                    lfsr    <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end else begin
                div_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (press_req) begin
                    if (press_bounce) begin
                        state_nx = BOUNCE_IN;
                        cnt_nx   = BOUNCE_M1;
                    end else begin
                        state_nx = HOLD;
                        cnt_nx   = req_hold_m1;
                    end
                end
            end
            BOUNCE_IN: begin
                if (cnt == 24'd0) begin
                    state_nx = HOLD;
                    cnt_nx   = hold_m1;
                end else begin
                    cnt_nx = cnt - 24'd1;
                end
            end
            HOLD: begin
                if (cnt == 24'd0) begin
                    state_nx = bounce_q ? BOUNCE_OUT : GAP;
                    cnt_nx   = bounce_q ? BOUNCE_M1 : GAP_M1;
                end else begin
                    cnt_nx = cnt - 24'd1;
                end
            end
            BOUNCE_OUT: begin
                if (cnt == 24'd0) begin
                    state_nx = GAP;
                    cnt_nx   = GAP_M1;
                end else begin
                    cnt_nx = cnt - 24'd1;
                end
            end
            GAP: begin
                if (cnt == 24'd0) begin
                    state_nx = IDLE;
                    cnt_nx   = 24'd0;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt - 24'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 24'd0;
            end
        endcase
    end

    // Rows follow the columns combinationally, as a real switch matrix does.
    always_comb begin
        busy    = (state != IDLE);
        done    = done_q;
        contact = 1'b0;
        case (state)
            BOUNCE_IN, BOUNCE_OUT: contact = lfsr[0];
            HOLD:                  contact = 1'b1;
            default:               contact = 1'b0;
        endcase
        keypad_hori = (contact && keypad_vert[key_q[1:0]]) ? (4'b0001 << key_q[3:2]) : 4'b0000;
    end
endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: vector table, random presses, reset and handshake corners.
module tb_keypad_emulator;
    localparam int BOUNCE = 8;
    localparam int DIV    = 2;
    localparam int GAP    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        press_req;
    logic [3:0]  press_key;
    logic [23:0] press_hold;
    logic        press_bounce;
    logic        busy, done, contact;
    logic [3:0]  keypad_vert, keypad_hori;

    int errors = 0;
    int checks = 0;
    logic [15:0] lf_m = 16'hACE1;

    typedef struct {
        logic [3:0]  key;
        logic [23:0] hold;
        logic        bounce;
        int          vmode;    // 0 cycling one-hot, 1 fixed 4'b0001, 2 random
        int          busy_len; // expected busy cycles
    } vec_t;

    vec_t vecs[5];

    keypad_emulator #(.BOUNCE_CYCLES(BOUNCE), .CHATTER_DIV(DIV), .GAP_CYCLES(GAP),
                      .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .reset(reset), .press_req(press_req), .press_key(press_key),
        .press_hold(press_hold), .press_bounce(press_bounce), .busy(busy), .done(done),
        .keypad_vert(keypad_vert), .keypad_hori(keypad_hori), .contact(contact));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic logic [3:0] row_exp(input logic c, input logic [3:0] k, input logic [3:0] v);
        logic [3:0] r;
        r = 4'b0000;
        if (c && v[k[1:0]]) r[k[3:2]] = 1'b1;
        return r;
    endfunction

    // Caller has set press_req and parameters at a negedge; the next edge is edge 0.
    // Returns 1ns into the done cycle so a caller may chain another request.
    task automatic run_press(input logic [3:0] k, input logic [23:0] h, input logic b,
                             input int vmode, input int total);
        int hl, idx, kk;
        logic ce, bph;
        hl = (h == 0) ? 1 : int'(h);
        for (int n = 1; n <= total + 1; n++) begin
            @(negedge clk);
            if (n == 1) press_req = 1'b0;
            if (n == 2 && total > 3) begin
                press_req = 1'b1; press_key = ~k; press_hold = 24'd3; press_bounce = ~b;
            end
            if (n == 3) press_req = 1'b0;
            case (vmode)
                0: keypad_vert = 4'b0001 << (n % 4);
                1: keypad_vert = 4'b0001;
                default: keypad_vert = 4'($urandom);
            endcase
            #1;
            if (n == total + 1) begin
                chk("done_pulse", done, 1'b1);
                chk("busy_end", busy, 1'b0);
                chk("contact_idle", contact, 1'b0);
                chk("hori_idle", keypad_hori, 4'b0000);
            end else begin
                idx = n - 1;
                bph = 1'b0; kk = 0;
                if (b && idx < BOUNCE) begin bph = 1'b1; kk = idx; end
                else if (idx < (b ? BOUNCE : 0) + hl) bph = 1'b0;
                else if (b && idx < 2 * BOUNCE + hl) begin bph = 1'b1; kk = idx - BOUNCE - hl; end
                if (bph) ce = lf_m[0];
                else ce = (idx < (b ? BOUNCE : 0) + hl);
                chk("busy", busy, 1'b1);
                chk("done_low", done, 1'b0);
                chk("contact", contact, ce);
                chk("hori", keypad_hori, row_exp(ce, k, keypad_vert));
                if (bph && ((kk + 1) % DIV == 0)) lf_m = lfsr_step(lf_m);
            end
        end
    endtask

    task automatic start(input logic [3:0] k, input logic [23:0] h, input logic b);
        press_req = 1'b1; press_key = k; press_hold = h; press_bounce = b;
    endtask

    task automatic idle_check();
        @(negedge clk);
        keypad_vert = 4'b1111;
        #1;
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);
        chk("idle_hori", keypad_hori, 4'b0000);
    endtask

    initial begin
        vecs[0] = '{key: 4'd6,  hold: 24'd100, bounce: 1'b0, vmode: 0, busy_len: 104};
        vecs[1] = '{key: 4'd6,  hold: 24'd100, bounce: 1'b0, vmode: 1, busy_len: 104};
        vecs[2] = '{key: 4'd15, hold: 24'd20,  bounce: 1'b1, vmode: 2, busy_len: 40};
        vecs[3] = '{key: 4'd3,  hold: 24'd0,   bounce: 1'b0, vmode: 2, busy_len: 5};
        vecs[4] = '{key: 4'd9,  hold: 24'd5,   bounce: 1'b1, vmode: 0, busy_len: 25};

        reset = 1'b1; press_req = 1'b0; press_key = 4'd0; press_hold = 24'd0;
        press_bounce = 1'b0; keypad_vert = 4'b1111;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_hori", keypad_hori, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_contact", contact, 1'b0);
        reset = 1'b0;
        idle_check();

        foreach (vecs[i]) begin
            @(negedge clk);
            start(vecs[i].key, vecs[i].hold, vecs[i].bounce);
            run_press(vecs[i].key, vecs[i].hold, vecs[i].bounce, vecs[i].vmode, vecs[i].busy_len);
            idle_check();
        end

        // Back-to-back: request held through the done cycle starts the next press at once.
        @(negedge clk);
        start(4'd5, 24'd0, 1'b0);
        run_press(4'd5, 24'd0, 1'b0, 2, 1 + GAP);
        start(4'd12, 24'd3, 1'b1);
        run_press(4'd12, 24'd3, 1'b1, 2, 2 * BOUNCE + 3 + GAP);
        idle_check();

        for (int r = 0; r < 8; r++) begin
            logic [3:0] k; logic [23:0] h; logic b; int hl;
            k = 4'($urandom); h = 24'($urandom_range(0, 30)); b = 1'($urandom);
            hl = (h == 0) ? 1 : int'(h);
            if (r % 2 == 0) @(negedge clk);
            start(k, h, b);
            run_press(k, h, b, 2, 2 * BOUNCE * int'(b) + hl + GAP);
            if (r % 2 == 1) idle_check();
        end

        // Abort: reset in mid-hold clears rows next cycle, no done, LFSR back to seed.
        @(negedge clk);
        start(4'd10, 24'd50, 1'b0);
        repeat (10) begin
            @(negedge clk);
            press_req = 1'b0;
        end
        keypad_vert = 4'b0100;
        #1;
        chk("abort_pre_hori", keypad_hori, 4'b0100);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_hori", keypad_hori, 4'b0000);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        reset = 1'b0;
        lf_m = 16'hACE1;
        repeat (3) idle_check();

        @(negedge clk);
        start(4'd1, 24'd2, 1'b1);
        run_press(4'd1, 24'd2, 1'b1, 2, 2 * BOUNCE + 2 + GAP);
        idle_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end
endmodule
